// File: rtl/matmul_pkg.sv
// Shared definitions for the packed matrix-multiplier datapath: element width and the
// loader state encoding that the result-side blocks reuse.
package matmul_pkg;

    localparam int ELEM_W = 8;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } load_state_t;

    // Element index width for an n x n matrix; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

endpackage

// File: rtl/matmul_operand_loader.sv
// Byte-serial loader: assembles A then B (row-major) into packed registers for the multiplier.
// Latency: m_valid rises the cycle after the final B element is accepted; pair period 2*N*N+1.
// Backpressure: s_ready drops while a complete pair is held; released the cycle after m_valid&&m_ready.
// Optional framing check on s_last is compiled in with MATLOAD_LAST_CHECK_EN.
module matmul_operand_loader
    import matmul_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ELEM_W-1:0]       s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    output logic [N*N*ELEM_W-1:0]   a_out,
    output logic [N*N*ELEM_W-1:0]   b_out,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    err
);

    localparam int NE    = N * N;
    localparam int IDX_W = idx_width(N);

    load_state_t        state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               accept;
    logic               idx_last;
    logic               final_elem;
    logic               a_we, b_we;

    assign s_ready    = (state == LOAD_A) || (state == LOAD_B);
    assign m_valid    = (state == HOLD);
    assign accept     = s_valid && s_ready;
    assign idx_last   = (idx == IDX_W'(NE - 1));
    assign final_elem = (state == LOAD_B) && idx_last;

`ifdef MATLOAD_LAST_CHECK_EN
    logic bad_last;
    logic err_set;
    logic err_q;

    // A premature s_last aborts the pair; a missing one is flagged but the pair is still delivered.
    assign bad_last = accept && s_last && !final_elem;
    assign err_set  = bad_last || (accept && final_elem && !s_last);
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end
`else
    logic bad_last;
    logic last_unused;

    assign bad_last    = 1'b0;
    assign last_unused = s_last;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        a_we      = 1'b0;
        b_we      = 1'b0;
        case (state)
            LOAD_A, LOAD_B: begin
                if (accept) begin
                    if (bad_last) begin
                        state_nxt = LOAD_A;
                        idx_nxt   = '0;
                    end else begin
                        a_we = (state == LOAD_A);
                        b_we = (state == LOAD_B);
                        if (idx_last) begin
                            idx_nxt   = '0;
                            state_nxt = (state == LOAD_A) ? LOAD_B : HOLD;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_nxt = LOAD_A;
                end
            end
            default: begin
                state_nxt = LOAD_A;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Operands are overwritten element by element; bytes not yet reloaded keep the previous pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
        end else begin
            if (a_we) begin
                a_out[idx*ELEM_W +: ELEM_W] <= s_data;
            end
            if (b_we) begin
                b_out[idx*ELEM_W +: ELEM_W] <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Directed bench for matmul_operand_loader (N=2): load, HOLD backpressure, gapped input,
// async reset mid-load, back-to-back pairs, and the s_last framing check when enabled.
module tb_matmul_operand_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic        m_valid;
    logic        m_ready;
    logic        err;

    int compared;
    int mismatched;

    matmul_operand_loader #(.N(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_last  (s_last),
        .a_out   (a_out),
        .b_out   (b_out),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted element; s_ready must already be high.
    task automatic send(input logic [7:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                             input logic [7:0] v3, input logic [7:0] v4, input logic [7:0] v5,
                             input logic [7:0] v6, input logic [7:0] v7);
        send(v0, 1'b0); send(v1, 1'b0); send(v2, 1'b0); send(v3, 1'b0);
        send(v4, 1'b0); send(v5, 1'b0); send(v6, 1'b0); send(v7, 1'b1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n   = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();

        // Reset values
        check("rst_a", a_out, 32'h0);
        check("rst_b", b_out, 32'h0);
        check("rst_mvalid", {31'b0, m_valid}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_sready", {31'b0, s_ready}, 32'h1);
        rst_n = 1'b1;
        tick();
        check("post_rst_sready", {31'b0, s_ready}, 32'h1);

        // Basic stream 1,2,3,4 | 9,8,7,6 with m_ready high
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
        check("a_done_mvalid", {31'b0, m_valid}, 32'h0);
        send(8'd9, 1'b0); send(8'd8, 1'b0); send(8'd7, 1'b0);
        check("pre_final_mvalid", {31'b0, m_valid}, 32'h0);
        send(8'd6, 1'b1);
        check("basic_mvalid", {31'b0, m_valid}, 32'h1);
        check("basic_sready", {31'b0, s_ready}, 32'h0);
        check("basic_a", a_out, 32'h04030201);
        check("basic_b", b_out, 32'h06070809);
        tick();
        check("basic_mvalid_drop", {31'b0, m_valid}, 32'h0);
        check("basic_sready_back", {31'b0, s_ready}, 32'h1);
        check("basic_err", {31'b0, err}, 32'h0);

        // HOLD with m_ready low for 5 cycles; pending s_valid must not write
        m_ready = 1'b0;
        send_pair(8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd8, 8'd7, 8'd6);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        for (int c = 0; c < 5; c++) begin
            check("hold_mvalid", {31'b0, m_valid}, 32'h1);
            check("hold_sready", {31'b0, s_ready}, 32'h0);
            check("hold_a", a_out, 32'h04030201);
            check("hold_b", b_out, 32'h06070809);
            tick();
        end
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        check("hold_release_sready", {31'b0, s_ready}, 32'h1);
        check("hold_release_mvalid", {31'b0, m_valid}, 32'h0);
        check("hold_release_a_kept", a_out, 32'h04030201);

        // Gapped input: s_valid 1,0,1,0 with junk on the idle cycles
        for (int k = 0; k < 8; k++) begin
            send(8'((k + 1) * 10), (k == 7));
            if (k == 1) begin
                check("gap_partial_a", a_out, 32'h0403140A);
            end
            if (k < 7) begin
                s_valid = 1'b0;
                s_data  = 8'hFF;
                tick();
                check("gap_idle_mvalid", {31'b0, m_valid}, 32'h0);
            end
        end
        check("gap_mvalid", {31'b0, m_valid}, 32'h1);
        check("gap_a", a_out, 32'h281E140A);
        check("gap_b", b_out, 32'h50463C32);
        tick();

        // Asynchronous reset after 5 accepts
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0); send(8'd9, 1'b0);
        check("midload_b_partial", b_out, 32'h50463C09);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_a", a_out, 32'h0);
        check("async_rst_b", b_out, 32'h0);
        check("async_rst_mvalid", {31'b0, m_valid}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        send_pair(8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd8, 8'd7, 8'd6);
        check("reload_mvalid", {31'b0, m_valid}, 32'h1);
        check("reload_a", a_out, 32'h04030201);
        check("reload_b", b_out, 32'h06070809);

        // Back-to-back pairs, s_valid held high through the handshake cycle
        tick();
        send_pair(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        check("b2b1_mvalid", {31'b0, m_valid}, 32'h1);
        check("b2b1_a", a_out, 32'h04030201);
        check("b2b1_b", b_out, 32'h08070605);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        tick();
        check("b2b_gap_sready", {31'b0, s_ready}, 32'h1);
        send_pair(8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1);
        check("b2b2_mvalid", {31'b0, m_valid}, 32'h1);
        check("b2b2_a", a_out, 32'h05060708);
        check("b2b2_b", b_out, 32'h01020304);
        tick();

`ifdef MATLOAD_LAST_CHECK_EN
        // Premature s_last on element 3 aborts the pair and sets sticky err
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0);
        check("lc_err_before", {31'b0, err}, 32'h0);
        send(8'd4, 1'b1);
        check("lc_err_set", {31'b0, err}, 32'h1);
        check("lc_discard_a", a_out, 32'h00030201);
        check("lc_sready", {31'b0, s_ready}, 32'h1);
        send_pair(8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd8, 8'd7, 8'd6);
        check("lc_mvalid", {31'b0, m_valid}, 32'h1);
        check("lc_a", a_out, 32'h04030201);
        check("lc_b", b_out, 32'h06070809);
        check("lc_err_sticky", {31'b0, err}, 32'h1);
        tick();
`else
        check("err_tied_low", {31'b0, err}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
